// File: rtl/serial_sub4.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub4
//  Purpose  : Bit-serial subtractor D = A - B - Bin, LSB first, one bit per
//             clock through a single full-subtractor cell and a borrow FF.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_run   = 2'd1;
    localparam logic [1:0]    c_st_done  = 2'd2;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Holds the first WIDTH-1 difference bits; the last one comes straight from the cell.
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_amsb;
    logic             r_bmsb;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    logic w_a;
    logic w_b;
    logic w_diff;
    logic w_br_next;
    logic w_last;

    assign w_a       = r_sa[0];
    assign w_b       = r_sb[0];
    assign w_diff    = w_a ^ w_b ^ r_br;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_last    = (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_next = c_st_run;
            c_st_run:  if (w_last) w_state_next = c_st_done;
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_run:  busy = 1'b1;
            c_st_done: done = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: operand shifters, borrow FF and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_d    <= '0;
            r_bout <= 1'b0;
            r_v    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_sa   <= A;
                        r_sb   <= B;
                        r_br   <= Bin;
                        r_cnt  <= '0;
                        r_amsb <= A[WIDTH-1];
                        r_bmsb <= B[WIDTH-1];
                    end
                end
                c_st_run: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= {w_diff, r_res[WIDTH-2:1]};
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_d    <= {w_diff, r_res};
                        r_bout <= w_br_next;
                        // w_diff is the result MSB on the completing edge
                        r_v    <= (r_amsb != r_bmsb) && (w_diff != r_amsb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign D    = r_d;
    assign Bout = r_bout;
    assign V    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub4
//  Purpose  : Self-checking bench for serial_sub4 (table, corner sequences,
//             random and exhaustive operands against an arithmetic model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;

    serial_sub4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       v;
    } vec_t;

    int n_vec;
    int n_err;
    int n_done;
    int n_acc;

    logic [3:0] r_d;
    logic       r_bout;
    logic       r_v;

    always @(negedge clk) if (done) n_done++;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference from plain integer arithmetic.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        vec_t r;
        int   u;
        int   s;
        u      = int'(a) - int'(b) - int'(bin);
        s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.a    = a;
        r.b    = b;
        r.bin  = bin;
        r.d    = u[3:0];
        r.bout = (u < 0);
        r.v    = (s < -8) || (s > 7);
        return r;
    endfunction

    // Called 1 time unit after an edge with the FSM in IDLE; returns 1 unit
    // after the edge that brings it back to IDLE.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic poke);
        logic [3:0] held;
        held  = D;
        start = 1'b1;
        A     = a;
        B     = b;
        Bin   = bin;
        @(posedge clk); #1;
        n_acc++;
        start = 1'b0;
        A     = 4'($urandom);
        B     = 4'($urandom);
        Bin   = 1'($urandom);
        for (int k = 1; k <= WIDTH; k++) begin
            chk("busy_run", int'(busy), 1);
            chk("done_run", int'(done), 0);
            chk("d_held_run", int'(D), int'(held));
            if (poke && k == 2) begin
                start = 1'b1;
                A     = 4'd1;
                B     = 4'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("done_pulse", int'(done), 1);
        chk("busy_done", int'(busy), 0);
        r_d    = D;
        r_bout = Bout;
        r_v    = V;
        @(posedge clk); #1;
        chk("done_clear", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    vec_t tbl[5];
    vec_t e;
    int   snap;

    initial begin
        n_vec = 0; n_err = 0; n_done = 0; n_acc = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;

        // 9 - 3: -7 - 3 = -10 overflows the signed range
        tbl[0] = '{a:4'd9, b:4'd3, bin:1'b0, d:4'd6,  bout:1'b0, v:1'b1};
        tbl[1] = '{a:4'd3, b:4'd9, bin:1'b0, d:4'hA,  bout:1'b1, v:1'b1};
        tbl[2] = '{a:4'd0, b:4'd0, bin:1'b1, d:4'hF,  bout:1'b1, v:1'b0};
        tbl[3] = '{a:4'd8, b:4'd1, bin:1'b0, d:4'd7,  bout:1'b0, v:1'b1};
        tbl[4] = '{a:4'd7, b:4'hF, bin:1'b1, d:4'd7,  bout:1'b1, v:1'b0};

        repeat (2) @(posedge clk);
        #1;
        // start during reset must be ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(D), 0);
        chk("rst_bout", int'(Bout), 0);
        chk("rst_v", int'(V), 0);
        @(posedge clk); #1;
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0);
            chk("tbl_d", int'(r_d), int'(tbl[i].d));
            chk("tbl_bout", int'(r_bout), int'(tbl[i].bout));
            chk("tbl_v", int'(r_v), int'(tbl[i].v));
        end

        // start pulsed mid-RUN with new operands is ignored
        snap = n_done;
        do_op(4'd9, 4'd3, 1'b0, 1'b1);
        chk("poke_d", int'(r_d), 6);
        repeat (8) @(posedge clk);
        #1;
        chk("poke_one_done", n_done - snap, 1);
        chk("poke_idle", int'(busy), 0);
        chk("poke_held", int'(D), 6);

        // reset on the 2nd RUN edge aborts without a done pulse
        snap  = n_done;
        start = 1'b1; A = 4'd15; B = 4'd5; Bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_d", int'(D), 0);
        chk("abort_bout", int'(Bout), 0);
        chk("abort_v", int'(V), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", n_done - snap, 0);
        chk("abort_idle", int'(busy), 0);
        do_op(4'd5, 4'd5, 1'b0, 1'b0);
        chk("after_abort_d", int'(r_d), 0);
        chk("after_abort_bout", int'(r_bout), 0);

        // random operands
        for (int i = 0; i < 40; i++) begin
            e = model(4'($urandom), 4'($urandom), 1'($urandom));
            do_op(e.a, e.b, e.bin, 1'b0);
            chk("rnd_d", int'(r_d), int'(e.d));
            chk("rnd_bout", int'(r_bout), int'(e.bout));
            chk("rnd_v", int'(r_v), int'(e.v));
        end

        // exhaustive back-to-back sweep
        snap = n_done;
        n_acc = 0;
        for (int i = 0; i < 512; i++) begin
            e = model(4'(i >> 5), 4'(i >> 1), 1'(i));
            do_op(e.a, e.b, e.bin, 1'b0);
            chk("swp_d", int'(r_d), int'(e.d));
            chk("swp_bout", int'(r_bout), int'(e.bout));
            chk("swp_v", int'(r_v), int'(e.v));
        end
        chk("swp_done_count", n_done - snap, n_acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
